// File: rtl/ds_mult_ctrl.sv
// Sequencer for the digit-serial GF(2^M) systolic multiplier: latch operands, clear, stream b MSD-first, drain, capture.
// Every output is a flop loaded from next-state logic, so there is no path from any input to any output.
module ds_mult_ctrl #(
  parameter int M    = 16,
  parameter int D    = 4,
  parameter int PIPE = 2,
  localparam int N   = (M + D - 1) / D,
  localparam int CW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  a_in,
  input  logic [M-1:0]  b_in,
  output logic [M-1:0]  arr_a,
  output logic          arr_clr,
  output logic          arr_en,
  output logic [D-1:0]  arr_digit,
  output logic          arr_digit_last,
  output logic [CW-1:0] digit_cnt,
  output logic          capture,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int NP = N * D;
  localparam int PW = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, CAPT, DONE} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   a_q, a_d;
  logic [NP-1:0]  b_pad_q, b_pad_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  drain_q, drain_d;

  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic           clr_q, clr_d;
  logic           en_q, en_d;
  logic [D-1:0]   digit_q, digit_d;
  logic           last_q, last_d;
  logic           capture_q, capture_d;
  logic           out_valid_q, out_valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_pad_d = b_pad_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a_in;
          b_pad_d = NP'(b_in);
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST_DIGIT) begin
          cnt_d   = '0;
          drain_d = '0;
          state_d = (PIPE > 0) ? DRAIN : CAPT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (int'(drain_q) == PIPE - 1) begin
          state_d = CAPT;
        end else begin
          drain_d = drain_q + PW'(1);
        end
      end
      CAPT: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered in that state.
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    clr_d       = (state_d == LOAD);
    en_d        = (state_d == RUN);
    last_d      = (state_d == RUN) && (cnt_d == LAST_DIGIT);
    capture_d   = (state_d == CAPT);
    out_valid_d = (state_d == DONE);
    digit_d     = '0;

    // b_pad is consumed as a left shift register: its top digit is always the next one to issue.
    if (state_d == RUN) begin
      digit_d = b_pad_q[NP-1 -: D];
      b_pad_d = b_pad_q << D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_pad_q     <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      clr_q       <= 1'b0;
      en_q        <= 1'b0;
      digit_q     <= '0;
      last_q      <= 1'b0;
      capture_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_pad_q     <= b_pad_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      clr_q       <= clr_d;
      en_q        <= en_d;
      digit_q     <= digit_d;
      last_q      <= last_d;
      capture_q   <= capture_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign arr_a          = a_q;
  assign arr_clr        = clr_q;
  assign arr_en         = en_q;
  assign arr_digit      = digit_q;
  assign arr_digit_last = last_q;
  assign digit_cnt      = cnt_q;
  assign capture        = capture_q;
  assign out_valid      = out_valid_q;

endmodule

// File: tb/tb_ds_mult_ctrl.sv
// Bench for ds_mult_ctrl: a default instance (M=16,D=4,PIPE=2) and a padded one (M=13,D=4,PIPE=0),
// each checked cycle by cycle against a timeline model of one transaction.
module tb_ds_mult_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready;
  logic [31:0] a_in, b_in;
  int          sel;
  int          total = 0;
  int          bad = 0;

  logic        iv0, iv1;
  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);

  logic        rdy0, clr0, en0, last0, cap0, ov0, busy0;
  logic [15:0] aa0;
  logic [3:0]  dg0;
  logic [1:0]  cnt0;
  logic        rdy1, clr1, en1, last1, cap1, ov1, busy1;
  logic [12:0] aa1;
  logic [3:0]  dg1;
  logic [1:0]  cnt1;

  ds_mult_ctrl #(.M(16), .D(4), .PIPE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0),
    .a_in(a_in[15:0]), .b_in(b_in[15:0]), .arr_a(aa0), .arr_clr(clr0),
    .arr_en(en0), .arr_digit(dg0), .arr_digit_last(last0), .digit_cnt(cnt0),
    .capture(cap0), .out_valid(ov0), .out_ready(out_ready), .busy(busy0)
  );

  ds_mult_ctrl #(.M(13), .D(4), .PIPE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
    .a_in(a_in[12:0]), .b_in(b_in[12:0]), .arr_a(aa1), .arr_clr(clr1),
    .arr_en(en1), .arr_digit(dg1), .arr_digit_last(last1), .digit_cnt(cnt1),
    .capture(cap1), .out_valid(ov1), .out_ready(out_ready), .busy(busy1)
  );

  logic [31:0] o_rdy, o_clr, o_en, o_last, o_cap, o_ov, o_busy, o_a, o_dg, o_cnt;
  always_comb begin
    if (sel == 0) begin
      o_rdy = 32'(rdy0); o_clr = 32'(clr0); o_en = 32'(en0); o_last = 32'(last0);
      o_cap = 32'(cap0); o_ov = 32'(ov0); o_busy = 32'(busy0); o_a = 32'(aa0);
      o_dg = 32'(dg0); o_cnt = 32'(cnt0);
    end else begin
      o_rdy = 32'(rdy1); o_clr = 32'(clr1); o_en = 32'(en1); o_last = 32'(last1);
      o_cap = 32'(cap1); o_ov = 32'(ov1); o_busy = 32'(busy1); o_a = 32'(aa1);
      o_dg = 32'(dg1); o_cnt = 32'(cnt1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input bit check_a);
    chk({tag, "_rdy"}, o_rdy, 32'd1);
    chk({tag, "_busy"}, o_busy, 32'd0);
    chk({tag, "_clr"}, o_clr, 32'd0);
    chk({tag, "_en"}, o_en, 32'd0);
    chk({tag, "_last"}, o_last, 32'd0);
    chk({tag, "_cap"}, o_cap, 32'd0);
    chk({tag, "_ov"}, o_ov, 32'd0);
    chk({tag, "_dg"}, o_dg, 32'd0);
    if (check_a) begin
      chk({tag, "_a"}, o_a, 32'd0);
      chk({tag, "_cnt"}, o_cnt, 32'd0);
    end
  endtask

  // Model: accept at cycle 0 -> clear at 1, digits at 2..N+1, capture at N+2+PIPE, out_valid after.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int rdelay,
                         input bit offer, input logic [31:0] a2, input logic [31:0] b2);
    int m, p, n, d, cap_k, limit;
    logic [31:0] am, bm, ed;
    bit en, done;
    n = 4;
    d = 4;
    m = (sel == 0) ? 16 : 13;
    p = (sel == 0) ? 2 : 0;
    am = a & ((32'd1 << m) - 32'd1);
    bm = b & ((32'd1 << m) - 32'd1);
    cap_k = n + 2 + p;
    limit = cap_k + rdelay + 4;
    chk("pre_rdy", o_rdy, 32'd1);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    out_ready = 1'b0;
    done = 1'b0;
    for (int k = 1; k <= limit && !done; k++) begin
      tick();
      if (out_ready) begin
        chk("post_rdy", o_rdy, 32'd1);
        chk("post_busy", o_busy, 32'd0);
        chk("post_ov", o_ov, 32'd0);
        out_ready = 1'b0;
        done = 1'b1;
      end else begin
        en = (k >= 2) && (k <= n + 1);
        ed = en ? ((bm >> ((n - 1 - (k - 2)) * d)) & 32'hF) : 32'd0;
        chk("clr", o_clr, 32'(k == 1));
        chk("en", o_en, 32'(en));
        chk("digit", o_dg, ed);
        if (en) chk("cnt", o_cnt, 32'(k - 2));
        chk("last", o_last, 32'(k == n + 1));
        chk("cap", o_cap, 32'(k == cap_k));
        chk("ov", o_ov, 32'(k > cap_k));
        chk("rdy", o_rdy, 32'd0);
        chk("busy", o_busy, 32'd1);
        chk("arr_a", o_a, am);
        in_valid = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        if (k > cap_k) begin
          if (offer) begin
            in_valid = 1'b1;
            a_in = a2;
            b_in = b2;
          end
          if (k - cap_k - 1 == rdelay) out_ready = 1'b1;
        end
      end
    end
    if (!done) begin
      chk("timeout", 32'd0, 32'd1);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    sel = 0;
    tick();
    tick();
    chk_idle("rst0", 1'b1);
    sel = 1;
    #1;
    chk_idle("rst1", 1'b1);
    sel = 0;
    #1;
    rst_n = 1'b1;
    tick();

    // Basic sequence.
    run_txn(32'h1234, 32'hA53C, 0, 1'b0, 32'd0, 32'd0);
    tick();

    // Backpressure with a second pair offered while out_valid is held.
    run_txn(32'hBEEF, 32'h0F1E, 5, 1'b1, 32'h5A5A, 32'hC3C3);
    run_txn(32'h5A5A, 32'hC3C3, 1, 1'b0, 32'd0, 32'd0);

    // Reset in the middle of RUN.
    in_valid = 1'b1;
    a_in = 32'h7777;
    b_in = 32'h9999;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle("abort", 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_cap", o_cap, 32'd0);
      chk("abort_ov", o_ov, 32'd0);
    end

    // Padding, no drain stage.
    sel = 1;
    #1;
    run_txn(32'h0ABC, 32'h1FFF, 0, 1'b0, 32'd0, 32'd0);
    run_txn(32'h1FFF, 32'h0123, 2, 1'b0, 32'd0, 32'd0);

    // Idle noise on out_ready.
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'($urandom);
      sel = i % 2;
      tick();
      chk_idle("noise", 1'b0);
    end
    out_ready = 1'b0;

    // Randomized transactions on both instances.
    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 1));
      #1;
      run_txn($urandom, $urandom, int'($urandom_range(0, 3)), 1'b0, 32'd0, 32'd0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
